// File: rtl/mhp_pkg.sv
// Shared constants and types for the mhp record-BRAM datapath.
package mhp_pkg;

    localparam int BRAM_AW = 10;
    localparam int BRAM_DW = 8;

    localparam int REQ_SCS  = 0;
    localparam int REQ_SET  = 1;
    localparam int REQ_SEND = 2;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request above the last owner.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx
);

    logic [IW:0] s;

    // Scan from farthest to nearest so the nearest candidate wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        s      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            s = {1'b0, last} + (IW+1)'(i);
            if (s >= (IW+1)'(N_REQ))
                s = s - (IW+1)'(N_REQ);
            if (req[s[IW-1:0]]) begin
                onehot              = '0;
                onehot[s[IW-1:0]]   = 1'b1;
                idx                 = s[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Request/grant arbiter sharing the single-port record BRAM,
// with bounded round-robin bursts and tagged read return.
module bram_port_arbiter
    import mhp_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int AW        = BRAM_AW,
    parameter int DW        = BRAM_DW,
    parameter int MAX_BURST = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ-1:0]    i_we,
    input  logic [N_REQ*AW-1:0] i_addr,
    input  logic [N_REQ*DW-1:0] i_wdata,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_rvalid,
    output logic [DW-1:0]       o_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [AW-1:0]       o_mem_addr,
    output logic [DW-1:0]       o_mem_wdata,
    input  logic [DW-1:0]       i_mem_rdata
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

    arb_state_t     state;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  last_owner;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;

    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;

    logic access;
    logic own_req;
    logic others;
    logic expire;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (i_req),
        .last   (last_owner),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign own_req = i_req[owner];
    assign access  = |(o_gnt & i_req);
    assign others  = |(i_req & ~o_gnt);
    assign cnt_nx  = (cnt == CMAX) ? cnt : cnt + CW'(1);
    assign expire  = (cnt_nx == CMAX) && others;
    assign o_rdata = i_mem_rdata;

    // Only the owner's buses reach the BRAM, and only on access cycles.
    always_comb begin
        o_mem_en    = access;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (access) begin
            o_mem_we    = i_we[owner];
            o_mem_addr  = i_addr[owner*AW +: AW];
            o_mem_wdata = i_wdata[owner*DW +: DW];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ARB;
            o_gnt      <= '0;
            o_rvalid   <= '0;
            cnt        <= '0;
            owner      <= '0;
            last_owner <= IW'(N_REQ - 1);
        end else begin
            o_rvalid <= o_gnt & {N_REQ{access & ~i_we[owner]}};
            unique case (state)
                ARB: begin
                    if (|i_req) begin
                        state <= OWN;
                        o_gnt <= pick_oh;
                        owner <= pick_idx;
                        cnt   <= '0;
                    end
                end
                OWN: begin
                    if (!own_req || expire) begin
                        state      <= ARB;
                        o_gnt      <= '0;
                        last_owner <= owner;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule
